// File: rtl/pipe_latch_pkg.sv
// pipe_latch_pkg: shared constants and control-field type for the generic pipeline latch.
`default_nettype none

package pipe_latch_pkg;

  localparam int REQ_RD_IDX     = 0;
  localparam int REQ_WR_IDX     = 1;
  localparam int PIPE_DEPTH_MAX = 4;
  localparam int PIPE_REQ_W     = 2;

  typedef struct packed {
    logic                  valid;
    logic [PIPE_REQ_W-1:0] req;
    logic                  halt;
  } stage_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipe_latch_stage.sv
// pipe_latch_stage: one register stage of the pipeline latch with kill > load > clear-request > hold.
`default_nettype none

module pipe_latch_stage
  import pipe_latch_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int REQ_W  = 2
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load_i,
  input  logic              kill_i,
  input  logic              clr_req_i,
  input  logic              valid_i,
  input  logic [REQ_W-1:0]  req_i,
  input  logic              halt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [REQ_W-1:0]  req_o,
  output logic              halt_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [REQ_W-1:0]  req_q, req_d;
  logic              halt_q, halt_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    req_d   = req_q;
    halt_d  = halt_q;
    data_d  = data_q;
    if (kill_i) begin
      // Payload is deliberately kept so a flushed slot still shows its last data.
      valid_d = 1'b0;
      req_d   = '0;
      halt_d  = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      req_d   = req_i;
      halt_d  = halt_i;
      data_d  = data_i;
    end else if (clr_req_i) begin
      req_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      req_q   <= '0;
      halt_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      req_q   <= req_d;
      halt_q  <= halt_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign req_o   = req_q;
  assign halt_o  = halt_q;
  assign data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_latch_gen.sv
// pipe_latch_gen: DEPTH-stage inter-stage pipeline register with ack-cleared requests and sticky halt.
// Optional bubble/stall counters are enabled by defining PIPE_LATCH_STATS_EN.
`default_nettype none

module pipe_latch_gen
  import pipe_latch_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int REQ_W  = 2,
  parameter int DEPTH  = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              ack,
  input  logic              in_valid,
  input  logic [REQ_W-1:0]  in_req,
  input  logic              in_halt,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [REQ_W-1:0]  out_req,
  output logic              out_halt,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_LATCH_STATS_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  if (DEPTH < 1 || DEPTH > PIPE_DEPTH_MAX) begin : g_bad_depth
    $error("pipe_latch_gen: DEPTH must be in 1..%0d", PIPE_DEPTH_MAX);
  end

  logic              stg_vin   [DEPTH];
  logic [REQ_W-1:0]  stg_rin   [DEPTH];
  logic              stg_hin   [DEPTH];
  logic [DATA_W-1:0] stg_din   [DEPTH];
  logic              stg_valid [DEPTH];
  logic [REQ_W-1:0]  stg_req   [DEPTH];
  logic              stg_halt  [DEPTH];
  logic [DATA_W-1:0] stg_data  [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Bubbles must never issue a memory request.
      assign stg_vin[k] = in_valid;
      assign stg_rin[k] = in_valid ? in_req : '0;
      assign stg_hin[k] = in_halt;
      assign stg_din[k] = in_data;
    end else begin : g_body
      assign stg_vin[k] = stg_valid[k-1];
      assign stg_rin[k] = stg_req[k-1];
      assign stg_hin[k] = stg_halt[k-1];
      assign stg_din[k] = stg_data[k-1];
    end

    pipe_latch_stage #(
      .DATA_W (DATA_W),
      .REQ_W  (REQ_W)
    ) u_stage (
      .CLK       (CLK),
      .nRST      (nRST),
      .load_i    (en),
      .kill_i    (flush),
      .clr_req_i ((k == DEPTH - 1) ? ack : 1'b0),
      .valid_i   (stg_vin[k]),
      .req_i     (stg_rin[k]),
      .halt_i    (stg_hin[k]),
      .data_i    (stg_din[k]),
      .valid_o   (stg_valid[k]),
      .req_o     (stg_req[k]),
      .halt_o    (stg_halt[k]),
      .data_o    (stg_data[k])
    );
  end

  // Final-stage halt is latched here so a flush or later shift cannot drop it.
  logic halt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      halt_q <= 1'b0;
    end else if (stg_halt[DEPTH-1]) begin
      halt_q <= 1'b1;
    end
  end

  assign out_valid = stg_valid[DEPTH-1];
  assign out_req   = stg_req[DEPTH-1];
  assign out_halt  = halt_q | stg_halt[DEPTH-1];
  assign out_data  = stg_data[DEPTH-1];

`ifdef PIPE_LATCH_STATS_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] stall_cnt_q;
  logic        bubble_evt;
  logic        stall_evt;

  assign bubble_evt = flush | (en & ~stg_vin[DEPTH-1]);
  assign stall_evt  = ~en & ~flush & stg_valid[DEPTH-1];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bubble_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (bubble_evt && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_latch_gen.sv
// tb_pipe_latch_gen: directed checks of pipe_latch_gen at DEPTH 1, 2 and 3 driven from shared inputs.
`default_nettype none

module tb_pipe_latch_gen;

  localparam int DW = 96;
  localparam int RW = 2;

  logic          CLK;
  logic          nRST;
  logic          en, flush, ack, in_valid, in_halt;
  logic [RW-1:0] in_req;
  logic [DW-1:0] in_data;

  logic          v1, v2, v3, h1, h2, h3;
  logic [RW-1:0] r1, r2, r3;
  logic [DW-1:0] d1, d2, d3;
`ifdef PIPE_LATCH_STATS_EN
  logic [31:0]   bc1, sc1, bc2, sc2, bc3, sc3;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  pipe_latch_gen #(.DATA_W(DW), .REQ_W(RW), .DEPTH(1)) u1 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .ack(ack),
    .in_valid(in_valid), .in_req(in_req), .in_halt(in_halt), .in_data(in_data),
    .out_valid(v1), .out_req(r1), .out_halt(h1), .out_data(d1)
`ifdef PIPE_LATCH_STATS_EN
    , .bubble_cnt(bc1), .stall_cnt(sc1)
`endif
  );

  pipe_latch_gen #(.DATA_W(DW), .REQ_W(RW), .DEPTH(2)) u2 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .ack(ack),
    .in_valid(in_valid), .in_req(in_req), .in_halt(in_halt), .in_data(in_data),
    .out_valid(v2), .out_req(r2), .out_halt(h2), .out_data(d2)
`ifdef PIPE_LATCH_STATS_EN
    , .bubble_cnt(bc2), .stall_cnt(sc2)
`endif
  );

  pipe_latch_gen #(.DATA_W(DW), .REQ_W(RW), .DEPTH(3)) u3 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush), .ack(ack),
    .in_valid(in_valid), .in_req(in_req), .in_halt(in_halt), .in_data(in_data),
    .out_valid(v3), .out_req(r3), .out_halt(h3), .out_data(d3)
`ifdef PIPE_LATCH_STATS_EN
    , .bubble_cnt(bc3), .stall_cnt(sc3)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic f, input logic a, input logic v,
                       input logic [RW-1:0] r, input logic h, input logic [DW-1:0] d);
    en = e; flush = f; ack = a; in_valid = v; in_req = r; in_halt = h; in_data = d;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

`ifdef PIPE_LATCH_STATS_EN
  logic [31:0] stall_before;
`endif

  initial begin
    nRST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    #12;
    chk("rst_v1", v1, 1'b0);
    chk("rst_d3", d3, '0);
    chk("rst_h2", h2, 1'b0);
    nRST = 1'b1;
    step();
    chk("idle_v1", v1, 1'b0);

    // Two-word stream through all depths
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 96'hA5);
    step();
    chk("e1_d1", d1, 96'hA5);
    chk("e1_r1", r1, 2'b01);
    chk("e1_v2", v2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 96'h5A);
    step();
    chk("e2_d2", d2, 96'hA5);
    chk("e2_r2", r2, 2'b01);
    chk("e2_v3", v3, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 96'h33);
    step();
    chk("e3_d2", d2, 96'h5A);
    chk("e3_r2", r2, 2'b10);
    chk("e3_d3", d3, 96'hA5);
    chk("e3_r3", r3, 2'b01);

    // Stall holds everything
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 96'hFF);
    step();
    chk("stall_d3", d3, 96'hA5);
    chk("stall_d1", d1, 96'h33);

    // Ack-only clears final-stage request but keeps data
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 96'h77);
    step();
    chk("ld_r1", r1, 2'b10);
    chk("ld_r3", r3, 2'b10);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 96'hEE);
    step();
    chk("ack_r1", r1, 2'b00);
    chk("ack_d1", d1, 96'h77);
    chk("ack_v1", v1, 1'b1);
    chk("ack_r3", r3, 2'b00);
    chk("ack_d3", d3, 96'h5A);

    // en and ack together: advance wins
    drive(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 96'h88);
    step();
    chk("enack_r1", r1, 2'b01);
    chk("enack_d1", d1, 96'h88);
    chk("enack_r2", r2, 2'b10);
    chk("enack_d3", d3, 96'h33);

    // Bubble with request bits set
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 96'h99);
    step();
    chk("bub_v1", v1, 1'b0);
    chk("bub_r1", r1, 2'b00);
    chk("bub_d1", d1, 96'h99);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 96'h11);
    step();
    chk("bub_v2", v2, 1'b0);
    chk("bub_r2", r2, 2'b00);
    chk("bub_d3", d3, 96'h88);

    // Fill depth 3, then flush
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 96'h22);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 96'h44);
    step();
    chk("full_v3", v3, 1'b1);
    chk("full_r3", r3, 2'b11);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 96'h55);
    step();
    chk("fl_v3", v3, 1'b0);
    chk("fl_r3", r3, 2'b00);
    chk("fl_d3", d3, 96'h11);
    chk("fl_d1", d1, 96'h44);
    chk("fl_v1", v1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 96'h66);
    step();
    chk("pf1_v3", v3, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    step();
    chk("pf2_v3", v3, 1'b0);
    step();
    chk("pf3_v3", v3, 1'b1);
    chk("pf3_d3", d3, 96'h66);
    chk("pf3_r3", r3, 2'b01);

    // Sticky halt
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 96'h12);
    step();
    chk("halt_h1", h1, 1'b1);
    chk("halt_h2", h2, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 96'h13);
    step();
    chk("hfl_h1", h1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 96'h20 + DW'(i));
      step();
      chk("hen_h1", h1, 1'b1);
    end
    chk("hen_h3", h3, 1'b0);
    chk("hen_h2", h2, 1'b0);

`ifdef PIPE_LATCH_STATS_EN
    chk("stat_bub_nz", (bc1 >= 32'd1), 1'b1);
    stall_before = sc1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, '0);
    step();
    chk("stat_stall_inc", sc1, stall_before + 32'd1);
`endif

    // Asynchronous reset mid-stream, away from a clock edge
    drive(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 96'hBEEF);
    step();
    step();
    step();
    chk("pre_v3", v3, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst_v3", v3, 1'b0);
    chk("arst_r3", r3, 2'b00);
    chk("arst_h1", h1, 1'b0);
    chk("arst_d3", d3, '0);
    chk("arst_d1", d1, '0);
    #3;
    nRST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    step();
    chk("post_h3", h3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
